// File: rtl/machine_timer_unit.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime/mtimecmp, prescaled tick,
// registered 1-cycle register port and level timer-interrupt request.
module machine_timer_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        reqValid,
  input  logic        reqWE,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspErr,
  output logic        reqTimerInterrupt
);

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4
  } reg_sel_e;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [63:0]           mtime_next;
  logic [31:0]           hi_shadow;
  logic                  en;
  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] cnt_next;

  logic [31:0] offset;
  logic        hit;
  reg_sel_e    sel;
  logic        rd;
  logic        wr;
  logic        tick;
  logic [31:0] rd_data;

  // Byte lanes are ignored; only word offsets are decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^reqAddr[1:0];

  assign offset = reqAddr - BASE_ADDR;

  // Address decode: only the five defined words inside the window are hits.
  always_comb begin
    hit = 1'b0;
    sel = REG_MTIME_LO;
    if ((offset[31:5] == '0) && (offset[4:2] <= 3'd4)) begin
      hit = 1'b1;
      sel = reg_sel_e'(offset[4:2]);
    end
  end

  assign rd   = reqValid && !reqWE && hit;
  assign wr   = reqValid &&  reqWE && hit;
  assign tick = en && (cnt == div);

  // Next mtime: a write to either half wins and suppresses that cycle's increment.
  always_comb begin
    mtime_next = mtime;
    if (wr && (sel == REG_MTIME_LO)) begin
      mtime_next[31:0] = reqWData;
    end else if (wr && (sel == REG_MTIME_HI)) begin
      mtime_next[63:32] = reqWData;
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
  end

  // Prescaler: counts 0..DIV while enabled, cleared when disabled or CTRL is written.
  always_comb begin
    cnt_next = cnt + 1'b1;
    if ((wr && (sel == REG_CTRL)) || !en || (cnt == div)) begin
      cnt_next = '0;
    end
  end

  // Read mux over pre-update state; MTIME_HI reads the snapshot, not live mtime.
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_MTIME_LO: rd_data = mtime[31:0];
      REG_MTIME_HI: rd_data = hi_shadow;
      REG_CMP_LO:   rd_data = mtimecmp[31:0];
      REG_CMP_HI:   rd_data = mtimecmp[63:32];
      REG_CTRL: begin
        rd_data[31]             = en;
        rd_data[PRESCALE_W-1:0] = div;
      end
      default: rd_data = '0;
    endcase
  end

  // Timer state, control, snapshot and compare registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mtime             <= '0;
      mtimecmp          <= '1;
      en                <= 1'b0;
      div               <= '0;
      cnt               <= '0;
      hi_shadow         <= '0;
      reqTimerInterrupt <= 1'b0;
    end else begin
      mtime             <= mtime_next;
      cnt               <= cnt_next;
      reqTimerInterrupt <= (mtime >= mtimecmp);
      if (wr && (sel == REG_CMP_LO)) mtimecmp[31:0]  <= reqWData;
      if (wr && (sel == REG_CMP_HI)) mtimecmp[63:32] <= reqWData;
      if (wr && (sel == REG_CTRL)) begin
        en  <= reqWData[31];
        div <= reqWData[PRESCALE_W-1:0];
      end
      if (rd && (sel == REG_MTIME_LO)) begin
        hi_shadow <= mtime[63:32];
      end else if (wr && (sel == REG_MTIME_HI)) begin
        hi_shadow <= reqWData;
      end
    end
  end

  // Registered response, one cycle after each request.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rspValid <= 1'b0;
      rspData  <= '0;
      rspErr   <= 1'b0;
    end else begin
      rspValid <= reqValid;
      rspErr   <= reqValid && !hit;
      rspData  <= rd ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_machine_timer_unit.sv
// Self-checking bench for machine_timer_unit: scoreboard queue of expected
// responses, popped when the DUT returns each response.
module tb_machine_timer_unit;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] O_LO   = 32'h00;
  localparam logic [31:0] O_HI   = 32'h04;
  localparam logic [31:0] O_CLO  = 32'h08;
  localparam logic [31:0] O_CHI  = 32'h0C;
  localparam logic [31:0] O_CTRL = 32'h10;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWE = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWData = '0;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic        reqTimerInterrupt;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  machine_timer_unit #(
    .BASE_ADDR (BASE),
    .PRESCALE_W(8)
  ) dut (
    .clk              (clk),
    .rstN             (rstN),
    .reqValid         (reqValid),
    .reqWE            (reqWE),
    .reqAddr          (reqAddr),
    .reqWData         (reqWData),
    .rspValid         (rspValid),
    .rspData          (rspData),
    .rspErr           (rspErr),
    .reqTimerInterrupt(reqTimerInterrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request per call, driven at the falling edge; expectation queued.
  task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    e.tag  = tag;
    e.data = exp_d;
    e.err  = exp_e;
    reqValid = 1'b1;
    reqWE    = we;
    reqAddr  = addr;
    reqWData = wd;
    expq.push_back(e);
    @(negedge clk);
    reqValid = 1'b0;
    reqWE    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp_d);
    issue(tag, 1'b0, BASE + off, 32'h0, exp_d, 1'b0);
  endtask

  task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d);
    issue(tag, 1'b1, BASE + off, d, 32'h0, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Response monitor: rspValid must follow a sampled request by one cycle.
  initial begin
    logic sampled;
    exp_t e;
    forever begin
      @(posedge clk);
      sampled = reqValid && rstN;
      #1;
      if (rstN) begin
        check("rsp_valid", {63'd0, rspValid}, {63'd0, sampled});
        if (rspValid) begin
          if (expq.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = expq.pop_front();
            check({e.tag, "_data"}, {32'd0, rspData}, {32'd0, e.data});
            check({e.tag, "_err"}, {63'd0, rspErr}, {63'd0, e.err});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rstN = 1'b0;
    idle(3);
    rstN = 1'b1;
    idle(1);

    // Reset values
    check("rst_irq", {63'd0, reqTimerInterrupt}, 64'd0);
    rd("rst_lo",   O_LO,   32'h0);
    rd("rst_hi",   O_HI,   32'h0);
    rd("rst_clo",  O_CLO,  32'hFFFF_FFFF);
    rd("rst_chi",  O_CHI,  32'hFFFF_FFFF);
    rd("rst_ctrl", O_CTRL, 32'h0);

    // Prescaled count: DIV=3 gives one tick per 4 cycles
    wr("ctrl_div3", O_CTRL, 32'h8000_0003);
    idle(40);
    rd("div3_lo",   O_LO,   32'd10);
    rd("div3_hi",   O_HI,   32'd0);
    rd("div3_ctrl", O_CTRL, 32'h8000_0003);
    wr("ctrl_off1", O_CTRL, 32'h0);

    // Carry across the halves with snapshot read of the high word
    wr("set_lo", O_LO, 32'hFFFF_FFFE);
    wr("set_hi", O_HI, 32'h0);
    wr("ctrl_run", O_CTRL, 32'h8000_0000);
    rd("carry_lo1", O_LO, 32'hFFFF_FFFE);
    idle(2);
    rd("carry_hi1", O_HI, 32'h0);
    rd("carry_lo2", O_LO, 32'h0000_0002);
    rd("carry_hi2", O_HI, 32'h1);
    wr("ctrl_off2", O_CTRL, 32'h0);

    // Interrupt on compare, deassert when mtimecmp raised
    wr("clr_lo",  O_LO,  32'h0);
    wr("clr_hi",  O_HI,  32'h0);
    wr("cmp_lo",  O_CLO, 32'd20);
    wr("cmp_hi",  O_CHI, 32'h0);
    check("irq_pre", {63'd0, reqTimerInterrupt}, 64'd0);
    wr("ctrl_run2", O_CTRL, 32'h8000_0000);
    idle(20);
    check("irq_at20", {63'd0, reqTimerInterrupt}, 64'd0);
    idle(1);
    check("irq_rise", {63'd0, reqTimerInterrupt}, 64'd1);
    wr("cmp_raise", O_CLO, 32'd100);
    check("irq_hold", {63'd0, reqTimerInterrupt}, 64'd1);
    idle(1);
    check("irq_fall", {63'd0, reqTimerInterrupt}, 64'd0);
    wr("ctrl_off3", O_CTRL, 32'h0);

    // Write in a tick cycle drops the increment
    wr("ctrl_run3", O_CTRL, 32'h8000_0000);
    wr("tick_wr_lo", O_LO, 32'd5);
    rd("tick_rd_lo", O_LO, 32'd5);
    wr("ctrl_off4", O_CTRL, 32'h0);
    check("irq_low", {63'd0, reqTimerInterrupt}, 64'd0);

    // 64-bit wrap; all-ones mtime is above mtimecmp=100
    wr("max_lo", O_LO, 32'hFFFF_FFFF);
    wr("max_hi", O_HI, 32'hFFFF_FFFF);
    wr("ctrl_run4", O_CTRL, 32'h8000_0000);
    check("irq_max", {63'd0, reqTimerInterrupt}, 64'd1);
    rd("wrap_lo1", O_LO, 32'hFFFF_FFFF);
    check("irq_max2", {63'd0, reqTimerInterrupt}, 64'd1);
    rd("wrap_lo2", O_LO, 32'h0);
    check("irq_wrap", {63'd0, reqTimerInterrupt}, 64'd0);
    rd("wrap_hi", O_HI, 32'h0);
    wr("ctrl_off5", O_CTRL, 32'h0);

    // Error decode, no side effects, ignored byte bits, DIV field width
    wr("set77", O_LO, 32'h77);
    issue("err_wr20", 1'b1, BASE + 32'h20, 32'h1234, 32'h0, 1'b1);
    issue("err_wr14", 1'b1, BASE + 32'h14, 32'h5678, 32'h0, 1'b1);
    issue("err_rd14", 1'b0, BASE + 32'h14, 32'h0, 32'h0, 1'b1);
    issue("err_rd1c", 1'b0, BASE + 32'h1C, 32'h0, 32'h0, 1'b1);
    issue("err_below", 1'b0, BASE - 32'h4, 32'h0, 32'h0, 1'b1);
    rd("keep_lo", O_LO, 32'h77);
    issue("byte_clo", 1'b0, BASE + 32'h0B, 32'h0, 32'd100, 1'b0);
    wr("ctrl_wide", O_CTRL, 32'h7FFF_FFFF);
    rd("ctrl_rb", O_CTRL, 32'h0000_00FF);

    // Reset while a response is pending
    wr("set55", O_LO, 32'h55);
    begin
      exp_t e;
      e.tag = "rst_pend";
      e.data = 32'h55;
      e.err = 1'b0;
      reqValid = 1'b1;
      reqWE    = 1'b0;
      reqAddr  = BASE + O_LO;
      expq.push_back(e);
      @(posedge clk);
      #3;
      rstN     = 1'b0;
      reqValid = 1'b0;
      @(negedge clk);
      check("rst_drop", {63'd0, rspValid}, 64'd0);
      @(negedge clk);
      rstN = 1'b1;
    end
    idle(1);
    check("rst2_valid", {63'd0, rspValid}, 64'd0);
    check("rst2_irq", {63'd0, reqTimerInterrupt}, 64'd0);
    rd("rst2_lo",   O_LO,   32'h0);
    rd("rst2_clo",  O_CLO,  32'hFFFF_FFFF);
    rd("rst2_ctrl", O_CTRL, 32'h0);

    idle(3);
    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
